// File: rtl/aes_pkt_scheduler.sv
// Packet-level round-robin arbiter that shares one aes_api core between two sources
// and tags each returning cipher word with its source id and end-of-packet marker.
module aes_pkt_scheduler #(
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s0_valid,
  input  logic         s0_last,
  input  logic [127:0] s0_text,
  input  logic [288:0] s0_bypass,
  output logic         s0_ready,
  input  logic         s1_valid,
  input  logic         s1_last,
  input  logic [127:0] s1_text,
  input  logic [288:0] s1_bypass,
  output logic         s1_ready,
  output logic         aes_new,
  output logic         aes_last,
  output logic [127:0] aes_text,
  output logic [288:0] aes_bypass,
  input  logic         aes_cp_ready,
  output logic         out_valid,
  output logic         out_src,
  output logic         out_last,
  output logic         busy,
  output logic         err
);

  localparam int unsigned AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  // A forced-last packet carries one word beyond the CNT_W maximum, so counts get a spare bit
  localparam int unsigned TW = CNT_W + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(TAG_DEPTH);
  localparam logic [CNT_W-1:0] WC_MAX  = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;
  typedef struct packed {
    logic          src;
    logic [TW-1:0] count;
  } tag_t;

  state_t         state, state_next;
  logic           rr_ptr, cur_src, cur_src_next, grant, grant_src;
  logic [CNT_W-1:0] wc;
  logic [TW-1:0]  rc;
  tag_t           tag_mem [TAG_DEPTH];
  tag_t           head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  tag_count, tag_count_next;
  logic           sel_valid, sel_last, acc, wc_full, pkt_end, fifo_empty, pop, spurious, overlong;
  logic [127:0]   sel_text;
  logic [288:0]   sel_bypass;
  logic [1:0]     ready_q;
  logic           busy_q, err_q;

  // Granted-source mux, packet-end detection and return-path tag decode
  always_comb begin
    sel_valid      = cur_src ? s1_valid  : s0_valid;
    sel_last       = cur_src ? s1_last   : s0_last;
    sel_text       = cur_src ? s1_text   : s0_text;
    sel_bypass     = cur_src ? s1_bypass : s0_bypass;
    head           = tag_mem[rd_ptr];
    fifo_empty     = (tag_count == '0);
    acc            = (state == PKT) && sel_valid;
    wc_full        = (wc == WC_MAX);
    pkt_end        = acc && (sel_last || wc_full);
    overlong       = acc && wc_full && !sel_last;
    pop            = aes_cp_ready && !fifo_empty && (TW'(rc + TW'(1)) == head.count);
    spurious       = aes_cp_ready && fifo_empty;
    tag_count_next = tag_count + CW'(pkt_end) - CW'(pop);
    cur_src_next   = grant ? grant_src : cur_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Grant only when the tag FIFO has room, so the packet-end push never overflows
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_src  = rr_ptr;
    case (state)
      IDLE: begin
        if ((tag_count < DEPTH_C) && (s0_valid || s1_valid)) begin
          grant      = 1'b1;
          grant_src  = (s0_valid && s1_valid) ? rr_ptr : s1_valid;
          state_next = PKT;
        end
      end
      PKT: begin
        if (pkt_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_src    <= 1'b0;
      rr_ptr     <= 1'b0;
      ready_q    <= 2'b00;
      wc         <= '0;
      rc         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_count  <= '0;
      aes_new    <= 1'b0;
      aes_last   <= 1'b0;
      aes_text   <= '0;
      aes_bypass <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cur_src   <= cur_src_next;
      ready_q   <= (state_next == PKT) ? (cur_src_next ? 2'b10 : 2'b01) : 2'b00;
      if (grant)    wc <= '0;
      else if (acc) wc <= wc + CNT_W'(1);
      if (pkt_end) begin
        rr_ptr <= ~cur_src;
        wr_ptr <= wr_ptr + AW'(1);
      end
      aes_new  <= acc;
      aes_last <= pkt_end;
      if (acc) begin
        aes_text   <= sel_text;
        aes_bypass <= sel_bypass;
      end
      if (pop) begin
        rc     <= '0;
        rd_ptr <= rd_ptr + AW'(1);
      end else if (aes_cp_ready && !fifo_empty) begin
        rc <= rc + TW'(1);
      end
      tag_count <= tag_count_next;
      busy_q    <= (state_next == PKT) || (tag_count_next != '0);
      err_q     <= err_q || overlong || spurious;
    end
  end

  // Tag storage: {source, word count} per issued packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TAG_DEPTH); i++) tag_mem[i] <= '0;
    end else if (pkt_end) begin
      tag_mem[wr_ptr] <= '{src: cur_src, count: TW'(wc) + TW'(1)};
    end
  end

  assign s0_ready  = ready_q[0];
  assign s1_ready  = ready_q[1];
  assign busy      = busy_q;
  assign err       = err_q;
  assign out_valid = aes_cp_ready;
  assign out_src   = !fifo_empty && head.src;
  assign out_last  = pop;

endmodule

// File: tb/tb_aes_pkt_scheduler.sv
// Directed bench for aes_pkt_scheduler: scoreboard queues for the aes_api
// framing and for the tagged return path.
module tb_aes_pkt_scheduler;

  localparam int unsigned TAG_DEPTH = 4;
  localparam int unsigned CNT_W     = 3;
  localparam int          MAXW      = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s0_valid = 1'b0, s0_last = 1'b0, s0_ready;
  logic [127:0] s0_text = '0;
  logic [288:0] s0_bypass = '0;
  logic         s1_valid = 1'b0, s1_last = 1'b0, s1_ready;
  logic [127:0] s1_text = '0;
  logic [288:0] s1_bypass = '0;
  logic         aes_new, aes_last;
  logic [127:0] aes_text;
  logic [288:0] aes_bypass;
  logic         aes_cp_ready = 1'b0;
  logic         out_valid, out_src, out_last, busy, err;

  always #5 clk = ~clk;

  aes_pkt_scheduler #(.TAG_DEPTH(TAG_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_last(s0_last), .s0_text(s0_text), .s0_bypass(s0_bypass), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_last(s1_last), .s1_text(s1_text), .s1_bypass(s1_bypass), .s1_ready(s1_ready),
    .aes_new(aes_new), .aes_last(aes_last), .aes_text(aes_text), .aes_bypass(aes_bypass),
    .aes_cp_ready(aes_cp_ready), .out_valid(out_valid), .out_src(out_src), .out_last(out_last),
    .busy(busy), .err(err)
  );

  typedef struct {logic [127:0] text; logic [288:0] bp; logic last;} aes_exp_t;
  typedef struct {logic src; logic last;} ret_exp_t;

  aes_exp_t aes_q[$];
  ret_exp_t ret_q[$];
  int       grant_order[$];
  int       acc_cyc[$];
  int       checks = 0, passes = 0, cyc = 0, new_cnt = 0, last_cnt = 0;

  task automatic chk(input string tag, input logic [288:0] obs, input logic [288:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [288:0] mk_bp(input logic src, input logic [127:0] v);
    return {160'h5a5a, src, v};
  endfunction

  task automatic drive(input logic src, input logic v, input logic l, input logic [127:0] t);
    if (src) begin
      s1_valid = v; s1_last = l; s1_text = t; s1_bypass = mk_bp(1'b1, t);
    end else begin
      s0_valid = v; s0_last = l; s0_text = t; s0_bypass = mk_bp(1'b0, t);
    end
  endtask

  task automatic idle(input logic src);
    @(negedge clk);
    drive(src, 1'b0, 1'b0, '0);
  endtask

  // Words 0..n-1 of a packet; the (MAXW+1)th word of an unterminated packet is expected forced last
  task automatic send_pkt(input logic src, input int n, input int base, input bit mark_last);
    for (int i = 0; i < n; i++) begin
      logic [127:0] v;
      logic         lst, exp_last;
      int           t;
      v        = 128'(base + i);
      lst      = mark_last && (i == n - 1);
      exp_last = lst || (i == MAXW);
      @(negedge clk);
      drive(src, 1'b1, lst, v);
      t = 0;
      while (!(src ? s1_ready : s0_ready) && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        chk("ready_timeout", 289'(src ? s1_ready : s0_ready), 289'(1));
        return;
      end
      if (i == 0) grant_order.push_back(int'(src));
      acc_cyc.push_back(cyc);
      aes_q.push_back('{v, mk_bp(src, v), exp_last});
      ret_q.push_back('{src, exp_last});
    end
  endtask

  task automatic ret_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      aes_cp_ready = 1'b1;
      #1;
      if (ret_q.size() == 0) begin
        chk("ret_unexpected", 289'(out_valid), 289'(0));
      end else begin
        ret_exp_t e;
        e = ret_q.pop_front();
        chk("out_valid", 289'(out_valid), 289'(1));
        chk("out_src", 289'(out_src), 289'(e.src));
        chk("out_last", 289'(out_last), 289'(e.last));
      end
    end
    @(negedge clk);
    aes_cp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    aes_cp_ready = 1'b0;
    aes_q.delete();
    ret_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // aes_api framing monitor
  always @(negedge clk) begin
    if (rst_n && aes_new) begin
      new_cnt++;
      if (aes_last) last_cnt++;
      if (aes_q.size() == 0) begin
        chk("aes_new_unexpected", 289'(aes_new), 289'(0));
      end else begin
        aes_exp_t e;
        e = aes_q.pop_front();
        chk("aes_text", 289'(aes_text), 289'(e.text));
        chk("aes_bypass", aes_bypass, e.bp);
        chk("aes_last", 289'(aes_last), 289'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int exp_go[4];
    int t;
    exp_go = '{0, 1, 0, 1};
    #1;
    chk("rst_s0_ready", 289'(s0_ready), 289'(0));
    chk("rst_s1_ready", 289'(s1_ready), 289'(0));
    chk("rst_aes_new", 289'(aes_new), 289'(0));
    chk("rst_aes_last", 289'(aes_last), 289'(0));
    chk("rst_aes_text", 289'(aes_text), 289'(0));
    chk("rst_aes_bypass", aes_bypass, 289'(0));
    chk("rst_busy", 289'(busy), 289'(0));
    chk("rst_err", 289'(err), 289'(0));
    chk("rst_out_last", 289'(out_last), 289'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Three-word packet from source 0
    new_cnt = 0; last_cnt = 0;
    send_pkt(1'b0, 3, 1, 1'b1);
    idle(1'b0);
    repeat (2) @(negedge clk);
    chk("t1_new_cycles", 289'(new_cnt), 289'(3));
    chk("t1_last_cycles", 289'(last_cnt), 289'(1));
    chk("t1_busy", 289'(busy), 289'(1));
    ret_n(3);
    chk("t1_busy_drained", 289'(busy), 289'(0));

    // Both sources contending: round-robin alternation
    do_reset();
    grant_order.delete();
    fork
      begin send_pkt(1'b0, 2, 'h10, 1'b1); send_pkt(1'b0, 2, 'h12, 1'b1); idle(1'b0); end
      begin send_pkt(1'b1, 2, 'h20, 1'b1); send_pkt(1'b1, 2, 'h22, 1'b1); idle(1'b1); end
    join
    chk("t2_grant_count", 289'(grant_order.size()), 289'(4));
    for (int k = 0; k < 4 && k < grant_order.size(); k++)
      chk("t2_grant_order", 289'(grant_order[k]), 289'(exp_go[k]));
    ret_n(8);

    // Back-to-back single-word packets fill the tag FIFO
    do_reset();
    acc_cyc.delete();
    for (int k = 0; k < 4; k++) send_pkt(1'b0, 1, 'h30 + k, 1'b1);
    idle(1'b0);
    for (int k = 1; k < 4 && k < acc_cyc.size(); k++)
      chk("t3_grant_spacing", 289'(acc_cyc[k] - acc_cyc[k-1]), 289'(2));

    // Fifth packet held off until one packet returns
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 'h77);
    repeat (5) begin
      @(negedge clk);
      chk("t4_s1_blocked", 289'(s1_ready), 289'(0));
    end
    chk("t4_busy_full", 289'(busy), 289'(1));
    ret_n(1);
    chk("t4_no_grant_yet", 289'(s1_ready), 289'(0));
    @(negedge clk);
    chk("t4_grant_resumed", 289'(s1_ready), 289'(1));
    aes_q.push_back('{128'h77, mk_bp(1'b1, 128'h77), 1'b1});
    ret_q.push_back('{1'b1, 1'b1});
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, '0);
    ret_n(4);
    chk("t4_err_clean", 289'(err), 289'(0));

    // Spurious cipher word with nothing in flight
    do_reset();
    @(negedge clk);
    aes_cp_ready = 1'b1;
    #1;
    chk("t5_spur_valid", 289'(out_valid), 289'(1));
    chk("t5_spur_src", 289'(out_src), 289'(0));
    chk("t5_spur_last", 289'(out_last), 289'(0));
    @(negedge clk);
    aes_cp_ready = 1'b0;
    chk("t5_spur_err", 289'(err), 289'(1));
    chk("t5_spur_busy", 289'(busy), 289'(0));

    // Overlong packet: 8th word forced last, 9th word becomes its own packet
    do_reset();
    chk("t5_err_cleared", 289'(err), 289'(0));
    send_pkt(1'b0, 8, 'h40, 1'b0);
    idle(1'b0);
    chk("t5_overlong_err", 289'(err), 289'(1));
    send_pkt(1'b0, 1, 'h48, 1'b1);
    idle(1'b0);
    ret_n(9);
    chk("t5_err_sticky", 289'(err), 289'(1));

    // Asynchronous reset in the middle of a packet
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 'h60);
    t = 0;
    while (!s0_ready && t < 50) begin @(negedge clk); t++; end
    chk("t6_grant", 289'(s0_ready), 289'(1));
    aes_q.push_back('{128'h60, mk_bp(1'b0, 128'h60), 1'b0});
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 'h61);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_aes_new", 289'(aes_new), 289'(0));
    chk("t6_rst_aes_text", 289'(aes_text), 289'(0));
    chk("t6_rst_aes_bypass", aes_bypass, 289'(0));
    chk("t6_rst_s0_ready", 289'(s0_ready), 289'(0));
    chk("t6_rst_busy", 289'(busy), 289'(0));
    drive(1'b0, 1'b0, 1'b0, '0);
    aes_q.delete();
    ret_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    new_cnt = 0; last_cnt = 0;
    send_pkt(1'b0, 3, 1, 1'b1);
    idle(1'b0);
    repeat (2) @(negedge clk);
    chk("t6_new_cycles", 289'(new_cnt), 289'(3));
    chk("t6_last_cycles", 289'(last_cnt), 289'(1));
    ret_n(3);
    chk("t6_busy_drained", 289'(busy), 289'(0));
    chk("aes_q_drained", 289'(aes_q.size()), 289'(0));
    chk("ret_q_drained", 289'(ret_q.size()), 289'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
